// File: rtl/pb_arbiter_pkg.sv
// rtl/pb_arbiter_pkg.sv - shared constants, FSM state type and helpers for the pushbutton arbiter
//
// Contents:
//   NUM_PB       number of pushbuttons (keys 0..NUM_PB-1)
//   KEY_W        width of a key number
//   arb_state_e  arbiter FSM states
//   next_key()   key number after k, wrapping NUM_PB-1 -> 0
package pb_arbiter_pkg;

  localparam int NUM_PB = 10;
  localparam int KEY_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  function automatic logic [KEY_W-1:0] next_key(input logic [KEY_W-1:0] k);
    if (k >= KEY_W'(NUM_PB - 1)) begin
      return '0;
    end
    return k + KEY_W'(1);
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - synchronizer, debounce counter and press detector for one pushbutton
//
// Ports:
//   clk     system clock
//   n_rst   asynchronous active-low reset
//   pb_raw  raw asynchronous button level, active high
//   rise    one-cycle pulse when the debounced level goes 0 -> 1
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic pb_raw,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The toggle happens on the edge that would bring the count to DEBOUNCE_CYCLES,
  // so the register only ever has to hold values up to DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  always_comb begin
    sync1_d = pb_raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = ~level_q;
      rise_d  = ~level_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/pb_arbiter.sv
// rtl/pb_arbiter.sv - debounced pushbutton events arbitrated round-robin onto a valid/ready key port
//
// Ports:
//   clk        system clock
//   n_rst      asynchronous active-low reset
//   ncs        chip select, active low; high clears events and holds the arbiter idle
//   pb         raw pushbuttons, active high, index = key number
//   key_valid  a key event is offered
//   key_code   key number of the offered event, 0 when nothing is offered
//   key_ready  consumer accepts the offered event
//   key_drop   sticky: a press was lost because its key already had an unserved event
//   pending    per-key unserved-event bits
module pb_arbiter
  import pb_arbiter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              ncs,
  input  logic [NUM_PB-1:0] pb,
  output logic              key_valid,
  output logic [KEY_W-1:0]  key_code,
  input  logic              key_ready,
  output logic              key_drop,
  output logic [NUM_PB-1:0] pending
);

  logic [NUM_PB-1:0] rise;

  for (genvar g = 0; g < NUM_PB; g++) begin : g_db
    pb_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .n_rst (n_rst),
      .pb_raw(pb[g]),
      .rise  (rise[g])
    );
  end

  arb_state_e        state_q, state_d;
  logic [KEY_W-1:0]  key_code_q, key_code_d;
  logic [KEY_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NUM_PB-1:0] pending_q, pending_d;
  logic              key_drop_q, key_drop_d;
  logic [NUM_PB-1:0] clr_mask;

  logic              grant_found;
  logic [KEY_W-1:0]  grant_key;
  logic [KEY_W-1:0]  cand;
  int                cand_idx;

  // First pending key at or after rr_ptr, wrapping past the last key.
  always_comb begin
    grant_found = 1'b0;
    grant_key   = '0;
    cand        = '0;
    cand_idx    = 0;
    for (int i = 0; i < NUM_PB; i++) begin
      cand_idx = int'(rr_ptr_q) + i;
      if (cand_idx >= NUM_PB) begin
        cand_idx = cand_idx - NUM_PB;
      end
      cand = KEY_W'(cand_idx);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_key   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    key_code_d = key_code_q;
    rr_ptr_d   = rr_ptr_q;
    clr_mask   = '0;
    if (ncs) begin
      state_d    = IDLE;
      key_code_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            state_d    = OFFER;
            key_code_d = grant_key;
          end
        end
        OFFER: begin
          if (key_ready) begin
            state_d            = IDLE;
            key_code_d         = '0;
            rr_ptr_d           = next_key(key_code_q);
            clr_mask[key_code_q] = 1'b1;
          end
        end
        default: begin
          state_d    = IDLE;
          key_code_d = '0;
        end
      endcase
    end
  end

  // A press that lands on the edge its key is being served re-arms the bit
  // instead of counting as a drop: the old event is gone, the new one waits.
  always_comb begin
    pending_d  = (pending_q & ~clr_mask) | rise;
    key_drop_d = key_drop_q | (|(rise & pending_q & ~clr_mask));
    if (ncs) begin
      pending_d  = '0;
      key_drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      key_code_q <= '0;
      rr_ptr_q   <= '0;
      pending_q  <= '0;
      key_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_code_q <= key_code_d;
      rr_ptr_q   <= rr_ptr_d;
      pending_q  <= pending_d;
      key_drop_q <= key_drop_d;
    end
  end

  assign key_valid = (state_q == OFFER);
  assign key_code  = key_code_q;
  assign key_drop  = key_drop_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_pb_arbiter.sv
// tb/tb_pb_arbiter.sv - self-checking bench for pb_arbiter against a behavioural key-event model
module tb_pb_arbiter;

  localparam int D = 4;
  localparam int N = 10;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       ncs;
  logic [9:0] pb;
  logic       key_ready;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_drop;
  logic [9:0] pending;

  always #5 clk = ~clk;

  pb_arbiter #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .ncs      (ncs),
    .pb       (pb),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .key_drop (key_drop),
    .pending  (pending)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  bit auto_chk = 1'b1;
  int cyc      = 0;

  // Model: each key's raw level reaches the debouncer two edges late; a change is
  // accepted once the synced level has disagreed for D edges in a row; each accepted
  // press becomes an event one edge later; events are served oldest-pointer-first.
  bit m_s1[N], m_s2[N], m_deb[N], m_rise[N], m_pend[N];
  int m_run[N];
  bit m_drop, m_busy;
  int m_code, m_rr;
  int m_hs[$];
  int dut_hs[$];
  int dut_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_s1[k] = 0; m_s2[k] = 0; m_deb[k] = 0; m_rise[k] = 0; m_pend[k] = 0; m_run[k] = 0;
    end
    m_drop = 0; m_busy = 0; m_code = 0; m_rr = 0;
  endtask

  task automatic model_step();
    bit old_pend[N];
    int clr;
    clr = (m_busy && key_ready && !ncs) ? m_code : -1;
    for (int k = 0; k < N; k++) old_pend[k] = m_pend[k];
    if (ncs) begin
      for (int k = 0; k < N; k++) m_pend[k] = 0;
      m_drop = 0; m_busy = 0; m_code = 0;
    end else begin
      if (m_busy) begin
        if (key_ready) begin
          m_hs.push_back(m_code);
          m_rr = (m_code + 1) % N;
          m_busy = 0;
          m_code = 0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (!m_busy && old_pend[(m_rr + i) % N]) begin
            m_busy = 1;
            m_code = (m_rr + i) % N;
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (m_rise[k]) begin
          if (old_pend[k] && k != clr) m_drop = 1;
          m_pend[k] = 1;
        end else if (k == clr) begin
          m_pend[k] = 0;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      m_rise[k] = 0;
      if (m_s2[k] == m_deb[k]) begin
        m_run[k] = 0;
      end else if (m_run[k] + 1 == D) begin
        m_deb[k]  = !m_deb[k];
        m_run[k]  = 0;
        m_rise[k] = m_deb[k];
      end else begin
        m_run[k]++;
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = pb[k];
    end
  endtask

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k] = m_pend[k];
    return v;
  endfunction

  task automatic tick();
    if (n_rst && !ncs && key_ready && key_valid === 1'b1) begin
      dut_hs.push_back(int'(key_code));
      dut_cyc.push_back(cyc + 1);
    end
    @(posedge clk);
    cyc++;
    if (!n_rst) model_reset();
    else model_step();
    #1;
    if (auto_chk) begin
      chk("key_valid", key_valid, m_busy);
      chk("key_code", key_code, m_busy ? m_code : 0);
      chk("pending", pending, m_pend_vec());
      chk("key_drop", key_drop, m_drop);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (key_valid !== 1'b1 && n < 40);
    if (key_valid !== 1'b1) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic clear_logs();
    m_hs.delete();
    dut_hs.delete();
    dut_cyc.delete();
  endtask

  task automatic chk_order(input string tag);
    chk({tag, "_count"}, dut_hs.size(), m_hs.size());
    if (dut_hs.size() == m_hs.size()) begin
      foreach (m_hs[i]) chk({tag, "_code"}, dut_hs[i], m_hs[i]);
    end
  endtask

  initial begin
    int n;
    bit stable;
    n_rst = 1'b1; ncs = 1'b0; pb = '0; key_ready = 1'b0;
    model_reset();
    #2 n_rst = 1'b0;
    ticks(3);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_pending", pending, 0);
    chk("rst_drop", key_drop, 0);
    n_rst = 1'b1;
    ticks(2);

    // single press: valid D+4 edges after the first sampling edge, one cycle wide
    key_ready = 1'b1;
    pb[3] = 1'b1;
    wait_valid("single", n);
    chk("single_latency", n, D + 4);
    chk("single_code", key_code, 3);
    tick();
    chk("single_pulse", key_valid, 0);
    pb[3] = 1'b0;
    ticks(10);

    // bounce shorter than the debounce window yields nothing, then one event
    clear_logs();
    for (int i = 0; i < 20; i++) begin
      pb[5] = ((i / 2) % 2) == 0;
      tick();
    end
    chk("bounce_quiet", dut_hs.size(), 0);
    pb[5] = 1'b1;
    ticks(20);
    chk("bounce_events", dut_hs.size(), 1);
    if (dut_hs.size() == 1) chk("bounce_code", dut_hs[0], 5);
    pb[5] = 1'b0;
    ticks(10);

    // round robin from a fresh pointer
    n_rst = 1'b0;
    ticks(2);
    n_rst = 1'b1;
    clear_logs();
    pb[0] = 1'b1; pb[2] = 1'b1; pb[7] = 1'b1;
    ticks(30);
    chk("rr_count", dut_hs.size(), 3);
    if (dut_hs.size() == 3) begin
      chk("rr_first", dut_hs[0], 0);
      chk("rr_second", dut_hs[1], 2);
      chk("rr_third", dut_hs[2], 7);
      chk("rr_gap1", dut_cyc[1] - dut_cyc[0], 2);
      chk("rr_gap2", dut_cyc[2] - dut_cyc[1], 2);
    end
    pb = '0;
    ticks(12);
    clear_logs();
    pb[0] = 1'b1; pb[7] = 1'b1;
    ticks(20);
    chk_order("rr_again");
    pb = '0;
    ticks(12);

    // backpressure: offer holds, second press of the same key is dropped
    key_ready = 1'b0;
    pb[1] = 1'b1;
    wait_valid("bp", n);
    chk("bp_code", key_code, 1);
    stable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) pb[1] = 1'b0;
      if (i == 14) pb[1] = 1'b1;
      tick();
      if (key_valid !== 1'b1 || key_code !== 4'd1) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_drop", key_drop, 1);
    clear_logs();
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    ticks(5);
    key_ready = 1'b1;
    ticks(10);
    chk("bp_events", dut_hs.size(), 1);
    chk("bp_drop_sticky", key_drop, 1);

    // chip deselect abandons the offer
    pb = '0;
    ncs = 1'b1;
    tick();
    ncs = 1'b0;
    ticks(10);
    key_ready = 1'b0;
    pb[4] = 1'b1;
    wait_valid("ncs", n);
    chk("ncs_code", key_code, 4);
    clear_logs();
    ncs = 1'b1;
    tick();
    chk("ncs_valid", key_valid, 0);
    chk("ncs_pending", pending, 0);
    chk("ncs_drop", key_drop, 0);
    ncs = 1'b0;
    key_ready = 1'b1;
    ticks(12);
    chk("ncs_not_delivered", dut_hs.size(), 0);

    // reset mid-offer clears outputs without waiting for an edge
    pb[4] = 1'b0;
    ticks(10);
    key_ready = 1'b0;
    pb[4] = 1'b1;
    wait_valid("rst_offer", n);
    #3 n_rst = 1'b0;
    #1;
    chk("arst_valid", key_valid, 0);
    chk("arst_code", key_code, 0);
    chk("arst_pending", pending, 0);
    chk("arst_drop", key_drop, 0);
    model_reset();
    pb = '0;
    @(negedge clk);
    n_rst = 1'b1;
    ticks(12);

    // random presses, backpressure and occasional deselect
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 7) == 0) pb[k] = ~pb[k];
      end
      key_ready = ($urandom_range(0, 2) != 0);
      ncs = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
